// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// FETCH_PREFETCH_EN selects a 2-deep prefetch queue; otherwise a single instruction register.
package fetch_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [1:0]  RW_FETCH = 2'b00;

`ifdef FETCH_PREFETCH_EN
    localparam int unsigned FIFO_DEPTH = 2;
`else
    localparam int unsigned FIFO_DEPTH = 1;
`endif

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HOLD  = 2'd1,
        ST_FLUSH = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    // Sequential word address, confined to the addressable space.
    function automatic logic [XLEN-1:0] pc_next(input logic [XLEN-1:0] pc,
                                                input logic [XLEN-1:0] mask);
        return (pc + XLEN'(1)) & mask;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small circular queue of {pc, instr} entries between memory and decode.
// Push while full is accepted only when a pop happens in the same cycle.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic         i_flush,
    input  fetch_entry_t i_data,
    output fetch_entry_t o_head,
    output logic         o_full,
    output logic         o_empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned SLOTS = 1 << PTR_W;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    fetch_entry_t     r_mem [SLOTS];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    function automatic logic [PTR_W-1:0] ptr_adv(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    assign o_full  = (r_count == CNT_FULL);
    assign o_empty = (r_count == '0);
    assign w_pop   = i_pop && !o_empty;
    assign w_push  = i_push && (!o_full || w_pop);
    assign o_head  = r_mem[r_rd_ptr];

    // Flush wins over any concurrent push or pop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_mem    <= '{default: '0};
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= ptr_adv(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_adv(r_rd_ptr);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: issues sequential word fetches, queues them toward decode, handles redirects.
// Queue depth set by FETCH_PREFETCH_EN (see fetch_pkg).
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [XLEN-1:0] ADDR_MASK = 32'h0000_FFFF
) (
    input  logic            clk,
    input  logic            reset_n,
    output logic [XLEN-1:0] mem_addr,
    output logic [1:0]      mem_rw,
    output logic            mem_enable,
    input  logic [XLEN-1:0] mem_fetch,
    input  logic            mem_busy,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            instr_valid,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    input  logic            instr_ready
);

    fetch_state_e    r_state;
    logic [XLEN-1:0] r_pc;
    logic            w_full;
    logic            w_empty;
    logic            w_pop;
    logic            w_issue;
    fetch_entry_t    w_head;
    fetch_entry_t    w_push_data;

    assign instr_valid = !w_empty && (r_state != ST_FLUSH);
    assign w_pop       = instr_valid && instr_ready;
    // Memory read data is only meaningful in the issue cycle, so issue is decided combinationally.
    assign w_issue     = reset_n && !mem_busy && !redirect_valid && (!w_full || w_pop);

    assign mem_addr    = r_pc;
    assign mem_rw      = RW_FETCH;
    assign mem_enable  = w_issue;
    assign instr       = w_head.instr;
    assign instr_pc    = w_head.pc;

    assign w_push_data.pc    = r_pc;
    assign w_push_data.instr = mem_fetch;

    // Control state and PC; redirect overrides any issue in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_FLUSH;
            r_pc    <= RESET_PC;
        end else if (redirect_valid) begin
            r_state <= ST_FLUSH;
            r_pc    <= redirect_pc & ADDR_MASK;
        end else begin
            if (w_issue) begin
                r_pc <= pc_next(r_pc, ADDR_MASK);
            end
            unique case (r_state)
                ST_FLUSH:        r_state <= ST_RUN;
                ST_RUN, ST_HOLD: r_state <= w_issue ? ST_RUN : ST_HOLD;
                default:         r_state <= ST_FLUSH;
            endcase
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (w_issue),
        .i_pop   (w_pop),
        .i_flush (redirect_valid),
        .i_data  (w_push_data),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

endmodule
